// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg -- shared Wishbone definitions for the two-master arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT0, GRANT1)
//   CTI_*       : Wishbone B4 cycle-type identifier encodings
// -----------------------------------------------------------------------------
package wb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_e;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_timeout.sv
// -----------------------------------------------------------------------------
// wb_timeout -- counts consecutive strobe cycles that received no termination.
// Ports:
//   WB_CLK_I  : clock (rising edge)
//   WB_RST_NI : asynchronous active-low reset
//   enable    : a strobe cycle without termination is in progress
//   clear     : restart counting (termination, strobe low, grant change)
//   expired   : this is the LIMIT-th unterminated strobe cycle
// -----------------------------------------------------------------------------
module wb_timeout #(
   parameter int LIMIT = 255
) (
   input  logic WB_CLK_I,
   input  logic WB_RST_NI,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam int CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge WB_CLK_I or negedge WB_RST_NI) begin
      if (!WB_RST_NI) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + 1'b1;
      end
   end

   // The counter holds the number of earlier unterminated cycles, so the
   // current cycle is the LIMIT-th one when it reads LIMIT-1.
   assign expired = enable && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/wb_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_arbiter2 -- two-master Wishbone B4 arbiter onto one slave port.
// M0 is instruction fetch, M1 is data. Grant is held for the whole CYC
// window (bursts never split); ties go to the master that did not hold the
// last grant. All routing is combinational from the registered grant state.
//
// Parameters: WB_ADDR_WIDTH, WB_DATA_WIDTH, TIMEOUT_CYCLES
// Ports:
//   WB_CLK_I, WB_RST_NI              : clock, async active-low reset
//   Mx_ADR/DAT/WE/CTI/STB/CYC_I      : master requests (x = 0,1)
//   Mx_DAT/ACK/ERR/RTY/STALL_O       : responses to masters
//   S_ADR/DAT/WE/CTI/STB/CYC_O       : request to slave
//   S_DAT/ACK/ERR/RTY/STALL_I        : slave responses
//
// Build option: define WB_ARB_TIMEOUT_EN to abort a strobe that goes
// TIMEOUT_CYCLES cycles without termination (ERR to the master, grant
// released). Without it a hung slave holds the grant indefinitely.
// -----------------------------------------------------------------------------
module wb_arbiter2
   import wb_pkg::*;
#(
   parameter int WB_ADDR_WIDTH  = 32,
   parameter int WB_DATA_WIDTH  = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     WB_CLK_I,
   input  logic                     WB_RST_NI,
   // master 0 (instruction fetch)
   input  logic [WB_ADDR_WIDTH-1:0] M0_ADR_I,
   input  logic [WB_DATA_WIDTH-1:0] M0_DAT_I,
   input  logic                     M0_WE_I,
   input  logic [2:0]               M0_CTI_I,
   input  logic                     M0_STB_I,
   input  logic                     M0_CYC_I,
   output logic [WB_DATA_WIDTH-1:0] M0_DAT_O,
   output logic                     M0_ACK_O,
   output logic                     M0_ERR_O,
   output logic                     M0_RTY_O,
   output logic                     M0_STALL_O,
   // master 1 (data)
   input  logic [WB_ADDR_WIDTH-1:0] M1_ADR_I,
   input  logic [WB_DATA_WIDTH-1:0] M1_DAT_I,
   input  logic                     M1_WE_I,
   input  logic [2:0]               M1_CTI_I,
   input  logic                     M1_STB_I,
   input  logic                     M1_CYC_I,
   output logic [WB_DATA_WIDTH-1:0] M1_DAT_O,
   output logic                     M1_ACK_O,
   output logic                     M1_ERR_O,
   output logic                     M1_RTY_O,
   output logic                     M1_STALL_O,
   // slave
   output logic [WB_ADDR_WIDTH-1:0] S_ADR_O,
   output logic [WB_DATA_WIDTH-1:0] S_DAT_O,
   output logic                     S_WE_O,
   output logic [2:0]               S_CTI_O,
   output logic                     S_STB_O,
   output logic                     S_CYC_O,
   input  logic [WB_DATA_WIDTH-1:0] S_DAT_I,
   input  logic                     S_ACK_I,
   input  logic                     S_ERR_I,
   input  logic                     S_RTY_I,
   input  logic                     S_STALL_I
);

   arb_state_e state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic       gnt0, gnt1;
   logic       cyc_raw, stb_raw;
   logic       term;
   logic       to_expired;

   assign gnt0 = (state_q == GRANT0);
   assign gnt1 = (state_q == GRANT1);
   assign term = S_ACK_I | S_ERR_I | S_RTY_I;

   // ---------------------------------------------------------------------------
   // Optional strobe timeout
   // ---------------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
   logic to_enable, to_clear;

   // Uses the unmasked strobe so the forced CYC/STB drop on expiry does not
   // feed back into the expiry decision.
   assign to_enable = stb_raw & ~term;
   assign to_clear  = ~stb_raw | term | (state_d != state_q);

   wb_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .WB_CLK_I  (WB_CLK_I),
      .WB_RST_NI (WB_RST_NI),
      .enable    (to_enable),
      .clear     (to_clear),
      .expired   (to_expired)
   );
`else
   assign to_expired = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Grant FSM
   // ---------------------------------------------------------------------------
   // NOTE: state and last_grant both come out of reset via the async reset;
   // last_grant starts at 1 so M0 wins the first tie.
   always_ff @(posedge WB_CLK_I or negedge WB_RST_NI) begin
      if (!WB_RST_NI) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      // NOTE: hold-current defaults first keep every path assigned (no latches).
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (M0_CYC_I && M1_CYC_I) begin
               state_d = last_grant_q ? GRANT0 : GRANT1;
            end else if (M0_CYC_I) begin
               state_d = GRANT0;
            end else if (M1_CYC_I) begin
               state_d = GRANT1;
            end
         end
         GRANT0: begin
            if (to_expired) begin
               state_d      = IDLE;
               last_grant_d = 1'b0;
            end else if (!M0_CYC_I) begin
               state_d      = M1_CYC_I ? GRANT1 : IDLE;
               last_grant_d = 1'b0;
            end
         end
         GRANT1: begin
            if (to_expired) begin
               state_d      = IDLE;
               last_grant_d = 1'b1;
            end else if (!M1_CYC_I) begin
               state_d      = M0_CYC_I ? GRANT0 : IDLE;
               last_grant_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Request path: only the granted master reaches the slave
   // ---------------------------------------------------------------------------
   always_comb begin
      S_ADR_O = '0;
      S_DAT_O = '0;
      S_WE_O  = 1'b0;
      S_CTI_O = CTI_CLASSIC;
      cyc_raw = 1'b0;
      stb_raw = 1'b0;
      if (gnt0) begin
         S_ADR_O = M0_ADR_I;
         S_DAT_O = M0_DAT_I;
         S_WE_O  = M0_WE_I;
         S_CTI_O = M0_CTI_I;
         cyc_raw = M0_CYC_I;
         stb_raw = M0_STB_I;
      end else if (gnt1) begin
         S_ADR_O = M1_ADR_I;
         S_DAT_O = M1_DAT_I;
         S_WE_O  = M1_WE_I;
         S_CTI_O = M1_CTI_I;
         cyc_raw = M1_CYC_I;
         stb_raw = M1_STB_I;
      end
   end

   assign S_CYC_O = cyc_raw & ~to_expired;
   assign S_STB_O = stb_raw & ~to_expired;

   // ---------------------------------------------------------------------------
   // Response path. Terminations are gated with the granted master's CYC so a
   // late ack in the cycle CYC drops is discarded rather than misrouted.
   // ---------------------------------------------------------------------------
   logic live0, live1;
   assign live0 = gnt0 & M0_CYC_I & ~to_expired;
   assign live1 = gnt1 & M1_CYC_I & ~to_expired;

   assign M0_DAT_O   = gnt0 ? S_DAT_I : '0;
   assign M0_ACK_O   = live0 & S_ACK_I;
   assign M0_ERR_O   = (live0 & S_ERR_I) | (gnt0 & to_expired);
   assign M0_RTY_O   = live0 & S_RTY_I;
   assign M0_STALL_O = gnt0 ? S_STALL_I : M0_CYC_I;

   assign M1_DAT_O   = gnt1 ? S_DAT_I : '0;
   assign M1_ACK_O   = live1 & S_ACK_I;
   assign M1_ERR_O   = (live1 & S_ERR_I) | (gnt1 & to_expired);
   assign M1_RTY_O   = live1 & S_RTY_I;
   assign M1_STALL_O = gnt1 ? S_STALL_I : M1_CYC_I;

endmodule

// File: tb/tb_wb_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter2 -- directed self-checking bench for wb_arbiter2.
// Inputs change 1 time unit after a rising edge; outputs are compared after a
// further settle delay, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter2;
   import wb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          WB_CLK_I = 1'b0;
   logic          WB_RST_NI = 1'b0;
   logic [AW-1:0] M0_ADR_I, M1_ADR_I, S_ADR_O;
   logic [DW-1:0] M0_DAT_I, M1_DAT_I, S_DAT_O, S_DAT_I, M0_DAT_O, M1_DAT_O;
   logic          M0_WE_I, M0_STB_I, M0_CYC_I, M1_WE_I, M1_STB_I, M1_CYC_I;
   logic [2:0]    M0_CTI_I, M1_CTI_I, S_CTI_O;
   logic          M0_ACK_O, M0_ERR_O, M0_RTY_O, M0_STALL_O;
   logic          M1_ACK_O, M1_ERR_O, M1_RTY_O, M1_STALL_O;
   logic          S_WE_O, S_STB_O, S_CYC_O;
   logic          S_ACK_I, S_ERR_I, S_RTY_I, S_STALL_I;

   int checks   = 0;
   int failures = 0;

   always #5 WB_CLK_I = ~WB_CLK_I;

   wb_arbiter2 #(
      .WB_ADDR_WIDTH  (AW),
      .WB_DATA_WIDTH  (DW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .WB_CLK_I   (WB_CLK_I),   .WB_RST_NI  (WB_RST_NI),
      .M0_ADR_I   (M0_ADR_I),   .M0_DAT_I   (M0_DAT_I),   .M0_WE_I    (M0_WE_I),
      .M0_CTI_I   (M0_CTI_I),   .M0_STB_I   (M0_STB_I),   .M0_CYC_I   (M0_CYC_I),
      .M0_DAT_O   (M0_DAT_O),   .M0_ACK_O   (M0_ACK_O),   .M0_ERR_O   (M0_ERR_O),
      .M0_RTY_O   (M0_RTY_O),   .M0_STALL_O (M0_STALL_O),
      .M1_ADR_I   (M1_ADR_I),   .M1_DAT_I   (M1_DAT_I),   .M1_WE_I    (M1_WE_I),
      .M1_CTI_I   (M1_CTI_I),   .M1_STB_I   (M1_STB_I),   .M1_CYC_I   (M1_CYC_I),
      .M1_DAT_O   (M1_DAT_O),   .M1_ACK_O   (M1_ACK_O),   .M1_ERR_O   (M1_ERR_O),
      .M1_RTY_O   (M1_RTY_O),   .M1_STALL_O (M1_STALL_O),
      .S_ADR_O    (S_ADR_O),    .S_DAT_O    (S_DAT_O),    .S_WE_O     (S_WE_O),
      .S_CTI_O    (S_CTI_O),    .S_STB_O    (S_STB_O),    .S_CYC_O    (S_CYC_O),
      .S_DAT_I    (S_DAT_I),    .S_ACK_I    (S_ACK_I),    .S_ERR_I    (S_ERR_I),
      .S_RTY_I    (S_RTY_I),    .S_STALL_I  (S_STALL_I)
   );

   task automatic idle_inputs();
      M0_ADR_I = '0; M0_DAT_I = '0; M0_WE_I = 1'b0; M0_CTI_I = CTI_CLASSIC;
      M0_STB_I = 1'b0; M0_CYC_I = 1'b0;
      M1_ADR_I = '0; M1_DAT_I = '0; M1_WE_I = 1'b0; M1_CTI_I = CTI_CLASSIC;
      M1_STB_I = 1'b0; M1_CYC_I = 1'b0;
      S_DAT_I = '0; S_ACK_I = 1'b0; S_ERR_I = 1'b0; S_RTY_I = 1'b0; S_STALL_I = 1'b0;
   endtask

   task automatic step();
      @(posedge WB_CLK_I);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      WB_RST_NI = 1'b0;
      step();
      step();
      WB_RST_NI = 1'b1;
      #1;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      idle_inputs();
      WB_RST_NI = 1'b0;
      S_ACK_I = 1'b1;
      S_DAT_I = 32'hDEAD_BEEF;
      M0_ADR_I = 32'h44;
      #2;
      checks++; if (S_CYC_O !== 1'b0) begin failures++; $display("FAIL reset_s_cyc got=%0b exp=0", S_CYC_O); end
      checks++; if (S_STB_O !== 1'b0) begin failures++; $display("FAIL reset_s_stb got=%0b exp=0", S_STB_O); end
      checks++; if (S_ADR_O !== 32'h0) begin failures++; $display("FAIL reset_s_adr got=%0h exp=0", S_ADR_O); end
      checks++; if ({M0_ACK_O, M1_ACK_O, M0_STALL_O, M1_STALL_O} !== 4'b0000) begin failures++;
         $display("FAIL reset_resp got=%b exp=0000", {M0_ACK_O, M1_ACK_O, M0_STALL_O, M1_STALL_O}); end
      checks++; if (M0_DAT_O !== 32'h0) begin failures++; $display("FAIL reset_m0_dat got=%0h exp=0", M0_DAT_O); end
      do_reset();
   endtask

   // M0 alone: classic read, one-cycle arbitration, ack routed only to M0.
   task automatic test_single_m0();
      do_reset();
      M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_ADR_I = 32'h10; M0_CTI_I = CTI_CLASSIC;
      #1;
      checks++; if (S_CYC_O !== 1'b0) begin failures++; $display("FAIL single_idle_cyc got=%0b exp=0", S_CYC_O); end
      checks++; if (M0_STALL_O !== 1'b1) begin failures++; $display("FAIL single_wait_stall got=%0b exp=1", M0_STALL_O); end
      step();
      checks++; if ({S_CYC_O, S_STB_O} !== 2'b11) begin failures++; $display("FAIL single_grant_cycstb got=%b exp=11", {S_CYC_O, S_STB_O}); end
      checks++; if (S_ADR_O !== 32'h10) begin failures++; $display("FAIL single_adr got=%0h exp=10", S_ADR_O); end
      S_ACK_I = 1'b1; S_DAT_I = 32'hCAFE_1234;
      #1;
      checks++; if (M0_ACK_O !== 1'b1) begin failures++; $display("FAIL single_m0_ack got=%0b exp=1", M0_ACK_O); end
      checks++; if (M0_DAT_O !== 32'hCAFE_1234) begin failures++; $display("FAIL single_m0_dat got=%0h exp=cafe1234", M0_DAT_O); end
      checks++; if ({M1_ACK_O, M1_ERR_O, M1_RTY_O, M1_STALL_O} !== 4'b0000 || M1_DAT_O !== 32'h0) begin failures++;
         $display("FAIL single_m1_quiet got=%b/%0h exp=0000/0", {M1_ACK_O, M1_ERR_O, M1_RTY_O, M1_STALL_O}, M1_DAT_O); end
      step();
      // Late ack in the cycle M0 drops CYC must go nowhere.
      M0_CYC_I = 1'b0; M0_STB_I = 1'b0;
      #1;
      checks++; if ({M0_ACK_O, M1_ACK_O} !== 2'b00) begin failures++; $display("FAIL late_ack_discard got=%b exp=00", {M0_ACK_O, M1_ACK_O}); end
      checks++; if (S_CYC_O !== 1'b0) begin failures++; $display("FAIL late_ack_s_cyc got=%0b exp=0", S_CYC_O); end
      S_ACK_I = 1'b0;
      step();
      checks++; if ({S_CYC_O, S_ADR_O} !== 33'h0) begin failures++; $display("FAIL single_back_idle got=%0b/%0h exp=0/0", S_CYC_O, S_ADR_O); end
   endtask

   // Simultaneous requests: M0 first, direct handover, then alternating ties.
   task automatic test_tie();
      do_reset();
      M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_ADR_I = 32'h100;
      M1_CYC_I = 1'b1; M1_STB_I = 1'b1; M1_ADR_I = 32'h200;
      step();
      checks++; if (S_ADR_O !== 32'h100) begin failures++; $display("FAIL tie_first_m0 got=%0h exp=100", S_ADR_O); end
      checks++; if ({M0_STALL_O, M1_STALL_O} !== 2'b01) begin failures++; $display("FAIL tie_stalls got=%b exp=01", {M0_STALL_O, M1_STALL_O}); end
      M0_CYC_I = 1'b0; M0_STB_I = 1'b0;
      step();
      checks++; if ({S_CYC_O, S_ADR_O} !== {1'b1, 32'h200}) begin failures++; $display("FAIL tie_handover got=%0b/%0h exp=1/200", S_CYC_O, S_ADR_O); end
      M1_CYC_I = 1'b0; M1_STB_I = 1'b0;
      step();
      M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M1_CYC_I = 1'b1; M1_STB_I = 1'b1;
      step();
      checks++; if (S_ADR_O !== 32'h100) begin failures++; $display("FAIL tie_after_m1 got=%0h exp=100", S_ADR_O); end
      M0_CYC_I = 1'b0; M0_STB_I = 1'b0; M1_CYC_I = 1'b0; M1_STB_I = 1'b0;
      step();
      M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M1_CYC_I = 1'b1; M1_STB_I = 1'b1;
      step();
      checks++; if (S_ADR_O !== 32'h200) begin failures++; $display("FAIL tie_after_m0 got=%0h exp=200", S_ADR_O); end
      idle_inputs();
      step();
      step();
   endtask

   // M1 4-beat INCR burst keeps the grant while M0 waits.
   task automatic test_burst();
      logic [2:0]  cti;
      logic [31:0] adr;
      M1_CYC_I = 1'b1; M1_STB_I = 1'b1; M1_WE_I = 1'b1; M1_ADR_I = 32'h300;
      M1_DAT_I = 32'h55; M1_CTI_I = CTI_INCR;
      step();
      M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_ADR_I = 32'h400;
      for (int b = 0; b < 4; b++) begin
         cti = (b == 3) ? CTI_EOB : CTI_INCR;
         adr = 32'h300 + 32'(4 * b);
         M1_CTI_I = cti; M1_ADR_I = adr; S_ACK_I = 1'b1;
         #1;
         checks++; if ({M1_ACK_O, M0_STALL_O, M0_ACK_O} !== 3'b110) begin failures++;
            $display("FAIL burst_beat%0d_resp got=%b exp=110", b, {M1_ACK_O, M0_STALL_O, M0_ACK_O}); end
         checks++; if ({S_CTI_O, S_ADR_O, S_WE_O} !== {cti, adr, 1'b1}) begin failures++;
            $display("FAIL burst_beat%0d_req got=%0h/%0h/%0b exp=%0h/%0h/1", b, S_CTI_O, S_ADR_O, S_WE_O, cti, adr); end
         step();
      end
      M1_CYC_I = 1'b0; M1_STB_I = 1'b0; S_ACK_I = 1'b0;
      step();
      checks++; if (S_ADR_O !== 32'h400) begin failures++; $display("FAIL burst_m0_next got=%0h exp=400", S_ADR_O); end
      S_STALL_I = 1'b1;
      #1;
      checks++; if ({M0_STALL_O, M1_STALL_O} !== 2'b10) begin failures++; $display("FAIL stall_pass got=%b exp=10", {M0_STALL_O, M1_STALL_O}); end
      idle_inputs();
      step();
      step();
   endtask

   // Async reset in the middle of an M1 burst.
   task automatic test_reset_mid_burst();
      M1_CYC_I = 1'b1; M1_STB_I = 1'b1; M1_ADR_I = 32'h500; M1_CTI_I = CTI_INCR;
      step();
      S_ACK_I = 1'b1;
      step();
      #1;
      WB_RST_NI = 1'b0;
      #1;
      checks++; if ({S_CYC_O, S_STB_O, M1_ACK_O, M1_ERR_O, M1_RTY_O} !== 5'b0) begin failures++;
         $display("FAIL rst_mid_burst got=%b exp=00000", {S_CYC_O, S_STB_O, M1_ACK_O, M1_ERR_O, M1_RTY_O}); end
      step();
      WB_RST_NI = 1'b1;
      S_ACK_I = 1'b0;
      #1;
      checks++; if ({S_CYC_O, M1_STALL_O} !== 2'b01) begin failures++; $display("FAIL rst_release_idle got=%b exp=01", {S_CYC_O, M1_STALL_O}); end
      M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_ADR_I = 32'h600;
      step();
      checks++; if (S_ADR_O !== 32'h600) begin failures++; $display("FAIL rst_last_grant got=%0h exp=600", S_ADR_O); end
      idle_inputs();
      step();
      step();
   endtask

   // Slave never terminates an M0 strobe while M1 is pending.
   task automatic test_hung_slave();
      int err_seen;
      err_seen = 0;
      M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_ADR_I = 32'h700;
      step();
      M1_CYC_I = 1'b1; M1_STB_I = 1'b1; M1_ADR_I = 32'h800;
`ifdef WB_ARB_TIMEOUT_EN
      for (int k = 1; k < 8; k++) begin
         #1;
         checks++; if ({M0_ERR_O, S_CYC_O} !== 2'b01) begin failures++;
            $display("FAIL timeout_pre%0d got=%b exp=01", k, {M0_ERR_O, S_CYC_O}); end
         step();
      end
      #1;
      checks++; if ({M0_ERR_O, S_CYC_O, M1_ERR_O} !== 3'b100) begin failures++;
         $display("FAIL timeout_fire got=%b exp=100", {M0_ERR_O, S_CYC_O, M1_ERR_O}); end
      step();
      checks++; if ({M0_ERR_O, S_CYC_O} !== 2'b00) begin failures++; $display("FAIL timeout_idle got=%b exp=00", {M0_ERR_O, S_CYC_O}); end
      step();
      checks++; if ({S_CYC_O, S_ADR_O} !== {1'b1, 32'h800}) begin failures++; $display("FAIL timeout_m1_next got=%0b/%0h exp=1/800", S_CYC_O, S_ADR_O); end
`else
      for (int k = 0; k < 20; k++) begin
         #1;
         if (M0_ERR_O !== 1'b0) err_seen++;
         step();
      end
      checks++; if (err_seen != 0) begin failures++; $display("FAIL hung_no_err got=%0d exp=0", err_seen); end
      checks++; if ({S_CYC_O, S_ADR_O, M1_STALL_O} !== {1'b1, 32'h700, 1'b1}) begin failures++;
         $display("FAIL hung_hold got=%0b/%0h/%0b exp=1/700/1", S_CYC_O, S_ADR_O, M1_STALL_O); end
`endif
      idle_inputs();
      step();
      step();
   endtask

   initial begin
      test_reset();
      test_single_m0();
      test_tie();
      test_burst();
      test_reset_mid_burst();
      test_hung_slave();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 32, data width of all ports.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, STB-without-termination limit; used only under WB_ARB_TIMEOUT_EN.
REQ-004 SHALL have port WB_CLK_I  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port WB_RST_NI  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have, for x in {0,1}, ports Mx_ADR_I in WB_ADDR_WIDTH, Mx_DAT_I in WB_DATA_WIDTH, Mx_WE_I in 1, Mx_CTI_I in 3, Mx_STB_I in 1, Mx_CYC_I in 1 (Wishbone B4 master requests; M0 instruction fetch, M1 data).
REQ-007 SHALL have, for x in {0,1}, ports Mx_DAT_O out WB_DATA_WIDTH, Mx_ACK_O, Mx_ERR_O, Mx_RTY_O, Mx_STALL_O out 1 each (responses to masters).
REQ-008 SHALL have slave-side ports S_ADR_O, S_DAT_O, S_WE_O, S_CTI_O, S_STB_O, S_CYC_O (outputs, widths as REQ-006) and S_DAT_I, S_ACK_I, S_ERR_I, S_RTY_I, S_STALL_I (inputs, widths as REQ-007).

Function
REQ-009 SHALL implement state machine IDLE, GRANT0, GRANT1 plus 1-bit register last_grant.
REQ-010 In IDLE, SHALL move to GRANTx next edge when only Mx_CYC_I=1; when both=1, SHALL grant the master != last_grant.
REQ-011 Arbitration latency SHALL be exactly one cycle: request in IDLE at edge N, S_CYC_O=1 from edge N+1.
REQ-012 In GRANTx, SHALL hold grant while Mx_CYC_I=1 regardless of Mx_STB_I or CTI (CLASSIC, CONST, INCR, EOB all keep grant; bursts never split).
REQ-013 In GRANTx with Mx_CYC_I=0: SHALL go to GRANTy if My_CYC_I=1, else IDLE; last_grant<=x on every grant release.
REQ-014 In GRANTx, S_ADR_O/S_DAT_O/S_WE_O/S_CTI_O/S_STB_O/S_CYC_O SHALL equal the Mx_* inputs combinationally (S_CYC_O=Mx_CYC_I, S_STB_O=Mx_STB_I).
REQ-015 In IDLE, S_CYC_O and S_STB_O SHALL be 0; S_ADR_O, S_DAT_O, S_WE_O, S_CTI_O SHALL be 0.
REQ-016 Mx_ACK_O/ERR_O/RTY_O SHALL equal S_*_I only when GRANTx, else 0; Mx_DAT_O SHALL equal S_DAT_I when GRANTx, else 0.
REQ-017 Mx_STALL_O SHALL equal S_STALL_I when GRANTx; SHALL be 1 when not granted and Mx_CYC_I=1; else 0.
REQ-018 A slave termination arriving the cycle the granted master drops CYC SHALL be discarded (not routed to either master).
REQ-019 Non-granted master signals SHALL never reach slave outputs.

Reset
REQ-020 WB_RST_NI=0 SHALL asynchronously force state=IDLE, last_grant=1 (M0 wins first tie), timeout counter=0.
REQ-021 Reset mid-burst SHALL immediately drop S_CYC_O/S_STB_O to 0 and all Mx_ACK/ERR/RTY_O to 0; no partial grant survives deassertion.

Configuration
REQ-022 With WB_ARB_TIMEOUT_EN defined, SHALL count cycles with S_STB_O=1 and no S_ACK_I/S_ERR_I/S_RTY_I; counter cleared by any termination, by STB=0, or on grant change.
REQ-023 Under WB_ARB_TIMEOUT_EN, when counter reaches TIMEOUT_CYCLES SHALL assert Mx_ERR_O=1 for one cycle to the granted master, force S_CYC_O=0 that cycle, then enter IDLE with last_grant<=x.
REQ-024 Without WB_ARB_TIMEOUT_EN, no counter SHALL be synthesized and a hung slave SHALL hold grant indefinitely.

Structure
REQ-025 State enum (IDLE, GRANT0, GRANT1) and CTI encodings (CLASSIC=3'b000, CONST=3'b001, INCR=3'b010, EOB=3'b111) SHALL live in shared package wb_pkg.
REQ-026 Timeout counter SHALL be sub-module wb_timeout (enable, clear, expired), instantiated only under WB_ARB_TIMEOUT_EN.

Verification
REQ-027 M0 alone, read ADR=0x10, slave ACK one cycle later -> S_CYC_O=1 one cycle after request, M0_ACK_O=1 with M0_DAT_O=slave data, M1 outputs all 0.
REQ-028 M0 and M1 both raise CYC same edge after reset -> GRANT0 first; on M0 CYC drop, direct GRANT1 with no IDLE cycle; next tie grants M0.
REQ-029 M1 4-beat INCR burst (CTI 010,010,010,111) while M0 requests -> M1 keeps grant all 4 ACKs, M0_STALL_O=1 throughout, M0 granted after M1 CYC drops.
REQ-030 Reset asserted during GRANT1 burst beat 2 -> S_CYC_O=0 asynchronously, state IDLE, last_grant=1 after release.
REQ-031 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks M0 -> M0_ERR_O=1 for one cycle on 8th STB cycle, S_CYC_O=0 same cycle, then IDLE; pending M1 granted next.
